dma_fifo_rd_ctrl: RTL
=====================

# dma_fifo_rd_ctrl

Read-side controller for the DMA controller's dual-port FIFO RAM. It owns the read pointer, issues read strobes and addresses to the RAM's registered read port, and absorbs the RAM's pipelined read latency in a small prefetch buffer. The result is a valid/ready stream toward the AXI master datapath at one word per cycle. The write-side controller is clocked by the same clock, supplies `WR_PTR`, and uses the returned `RD_PTR` for its full calculation.

## Interface
- `WIDTH`, 128, data word width in bits; must equal the RAM width.
- `DEPTH`, 128, number of RAM entries; power of two, at least 4. Derived localparam `AW = log2(DEPTH)`.
- `CLOCK` in 1: single clock for the block and the RAM.
- `RESET_N` in 1: asynchronous, active-low reset.
- `WR_PTR` in AW+1: write pointer from the writer; binary, with a wrap bit in the MSB.
- `RD_PTR` out AW+1: read pointer returned to the writer; binary, with a wrap bit.
- `FLUSH` in 1: synchronous discard of all unread data.
- `RAM_REN` out 1: RAM read strobe (block enable).
- `RAM_RADDR` out AW: RAM read address, equal to `RD_PTR[AW-1:0]`.
- `RAM_RDATA` in WIDTH: RAM read data.
- `M_VALID` out 1: output word valid.
- `M_READY` in 1: downstream accepts the word.
- `M_DATA` out WIDTH: output word.
- `EMPTY` out 1: nothing unread in the RAM, in flight, or buffered.

## Operation
- Internal state:
  - `RD_PTR` register.
  - In-flight valid shift register, `LAT` stages.
  - 4-entry prefetch buffer with 2-bit head/tail pointers and a 3-bit count `OCC`.
- Issue rule: `RAM_REN = !FLUSH && (WR_PTR != RD_PTR) && (OCC + inflight < 4)`.
  - `inflight` is the number of set in-flight stages.
  - `RD_PTR` increments by 1 at each edge where `RAM_REN` is high, with natural wrap modulo 2·DEPTH.
- Return path: the in-flight bit shifts each cycle. When the last stage is set, `RAM_RDATA` is written to the buffer tail.
- Output:
  - `M_VALID = (OCC != 0)`; `M_DATA` is the buffer head entry.
  - A pop occurs on `M_VALID && M_READY`.
  - A push and a pop in the same cycle leave `OCC` unchanged.
- The credit rule makes buffer overflow impossible. A push while `OCC == 4` is a design error, flagged by a simulation assertion.
- `EMPTY = (WR_PTR == RD_PTR) && (inflight == 0) && (OCC == 0)`.
- `FLUSH` (sampled at the edge) performs all of the following, with no `RAM_REN` in that cycle:
  - `RD_PTR <= WR_PTR`.
  - In-flight bits cleared, so returning data is discarded.
  - `OCC`, head and tail cleared.
- Full/empty pointer semantics: equal pointers mean empty. Pointers that differ only in the MSB mean full; full is computed by the writer.
- Reset values: `RD_PTR` 0, in-flight bits 0, `OCC` 0, `M_VALID` 0, `M_DATA` 0, `RAM_REN` 0, `EMPTY` 1.
  - Reset asserted mid-transfer aborts everything immediately, with no handshake completion.
- Buffer storage needs no reset. `M_DATA` is forced to 0 while `OCC == 0`.

## Timing
- `RAM_REN` high in cycle c → `RAM_RDATA` valid in cycle c+LAT → word pushed at the end of cycle c+LAT → `M_VALID` in cycle c+LAT+1.
- `LAT` is 2 by default: one stage for the address register and one for the data register.
- Latency from a `WR_PTR` update (visible in cycle w) to `M_VALID`: LAT+2 cycles.
- Sustained throughput with `M_READY` held high: 1 word per cycle, because 4 credits exceed LAT+1.
- `M_VALID` and `M_DATA` hold stable while `M_VALID && !M_READY`.
- `RD_PTR` updates one edge after the `RAM_REN` cycle. The writer sees freed space only at that point; buffered words are already counted as read.

## Configuration
- `DMA_FIFO_RD_LAT1_EN`:
  - Defined: `LAT = 1`, for a RAM with its read data register bypassed. One in-flight stage; all latencies above reduce by 1.
  - Undefined: `LAT = 2`.
- The credit limit stays at 4 in both builds.

## Test plan
- Single word:
  - Stimulus: reset, then `WR_PTR` 0→1 in cycle 10, with `M_READY` high.
  - Required: `RAM_REN` in cycle 11 with `RAM_RADDR = 0`; `M_VALID` in cycle 14; `RD_PTR = 1`; `EMPTY` returns to 1 after the pop.
- Streaming:
  - Stimulus: `WR_PTR` = 64, with `M_READY` continuously high.
  - Required: 64 consecutive `M_VALID` cycles with data in address order and no bubbles after the first word; final `RD_PTR` = 64.
- Backpressure:
  - Stimulus: `WR_PTR` = 20, `M_READY` low for 10 cycles.
  - Required: exactly 4 `RAM_REN` pulses; `M_DATA` stable; `RD_PTR` = 4 until `M_READY` rises; all 20 words then delivered in order.
- Wrap-around:
  - Stimulus: preload `RD_PTR` and `WR_PTR` to 126, then write 4 words.
  - Required: `RAM_RADDR` sequence 126, 127, 0, 1; `RD_PTR` ends at 130 (MSB set).
- Flush:
  - Stimulus: `FLUSH` pulsed with 2 reads in flight and `OCC` = 2.
  - Required: `M_VALID` 0 the next cycle; no word appears from the in-flight reads; `RD_PTR` equals `WR_PTR`; `EMPTY` = 1.
- Reset:
  - Stimulus: `RESET_N` asserted asynchronously during streaming.
  - Required: all outputs take reset values immediately; the next word after release comes from address 0.

Source files
------------

// File: rtl/dma_fifo_rd_ctrl.sv
// dma_fifo_rd_ctrl
// Read-side controller for the DMA FIFO RAM. It owns the read pointer and
// issues reads to a RAM with a registered read port. A 4-entry prefetch
// buffer absorbs the RAM's read latency and presents the data as a
// valid/ready stream.
// Build option: define DMA_FIFO_RD_LAT1_EN for a RAM whose read data register
// is bypassed (read latency 1 instead of 2).
// WR_PTR is registered once on entry. All issue and empty decisions use that
// registered copy, so a write pointer change reaches M_VALID LAT+2 cycles later.
module dma_fifo_rd_ctrl #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [AW:0]      WR_PTR,
  output logic [AW:0]      RD_PTR,
  input  logic             FLUSH,
  output logic             RAM_REN,
  output logic [AW-1:0]    RAM_RADDR,
  input  logic [WIDTH-1:0] RAM_RDATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             EMPTY
);

`ifdef DMA_FIFO_RD_LAT1_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [LAT-1:0]   infl_q, infl_d;
  logic [LAT:0]     infl_shift;
  logic [2:0]       occ_q, occ_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [2:0]       infl_cnt;
  logic             ren;
  logic             push;
  logic             pop;

  // Count the reads still travelling through the RAM pipeline.
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      infl_cnt = infl_cnt + {2'b00, infl_q[i]};
    end
  end

  // Credit-based issue: buffered words plus reads in flight never exceed 4.
  assign ren  = !FLUSH && (wr_ptr_q != rd_ptr_q) &&
                (({1'b0, occ_q} + {1'b0, infl_cnt}) < 4'd4);
  assign push = infl_q[LAT-1] && !FLUSH;
  assign pop  = (occ_q != 3'd0) && M_READY && !FLUSH;

  // The in-flight shift register moves up one stage and takes this cycle's strobe at bit 0.
  assign infl_shift = {infl_q, ren};

  // Next-state logic for the pointers, the in-flight stages and the buffer bookkeeping.
  always_comb begin
    wr_ptr_d = WR_PTR;
    rd_ptr_d = rd_ptr_q;
    infl_d   = infl_shift[LAT-1:0];
    occ_d    = occ_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (FLUSH) begin
      rd_ptr_d = WR_PTR;
      infl_d   = '0;
      occ_d    = '0;
      head_d   = '0;
      tail_d   = '0;
    end else begin
      if (ren)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (push) tail_d   = tail_q + 2'd1;
      if (pop)  head_d   = head_q + 2'd1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers; an asynchronous reset aborts any transfer in progress.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      infl_q   <= '0;
      occ_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      infl_q   <= infl_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Prefetch storage has no reset; the data output is masked while the buffer is empty.
  always_ff @(posedge CLOCK) begin
    if (push) buf_q[tail_q] <= RAM_RDATA;
  end

  assign RD_PTR    = rd_ptr_q;
  assign RAM_REN   = ren;
  assign RAM_RADDR = rd_ptr_q[AW-1:0];
  assign M_VALID   = (occ_q != 3'd0);
  assign M_DATA    = (occ_q != 3'd0) ? buf_q[head_q] : '0;
  assign EMPTY     = (wr_ptr_q == rd_ptr_q) && (infl_cnt == 3'd0) && (occ_q == 3'd0);

  // Credits should make overflow impossible; a push into a full buffer is a design error.
  a_no_overflow: assert property (@(posedge CLOCK) disable iff (!RESET_N)
                                  !(push && (occ_q == 3'd4)));

endmodule
